piso_serializer: RTL and testbench

Parallel-in serial-out serializer that captures a WIDTH-bit word from a parallel register stage and shifts it out one bit per accepted serial beat, MSB first. It is the read-out end of the team's parallel register path: a load handshake on the parallel side and a valid/ready handshake on the serial side. A one-cycle completion pulse marks the end of each word.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_shreg.sv | 36 +++
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared state encoding and default word width for the PISO serializer.
package piso_pkg;

   localparam int PISO_DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } piso_state_t;

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit shift register: parallel load or MSB-first shift (zero fill), else hold.
// Only the MSB leaves the block because that is the only bit the serializer drives out.
module piso_shreg #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = d_i;
      end else if (shift_i) begin
         q_d = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign msb_o = q_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, valid/ready on the serial side; ser_ready low holds the current bit.
// Optional PISO_PARITY_EN appends an even-parity beat after the data bits.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] d,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   piso_state_t   state_q;
   logic [CW-1:0] cnt_q;
   logic          done_q;
   logic          sh_msb;
   logic          load_fire;
   logic          shift_fire;
`ifdef PISO_PARITY_EN
   logic          par_q;
`endif

   assign load_fire  = load_valid && (state_q == IDLE);
   assign shift_fire = ser_ready && (state_q == SHIFT);

   piso_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (load_fire),
      .shift_i(shift_fire),
      .d_i    (d),
      .msb_o  (sh_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_fire) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
`ifdef PISO_PARITY_EN
                  par_q   <= ^d;
`endif
               end
            end
            SHIFT: begin
               if (ser_ready) begin
                  // Counter parks on the last index so it never wraps inside a word.
                  if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                     state_q <= PAR;
`else
                     state_q <= IDLE;
                     done_q  <= 1'b1;
`endif
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
               if (ser_ready) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign ser_valid  = (state_q == SHIFT) || (state_q == PAR);
   assign done       = done_q;
`ifdef PISO_PARITY_EN
   assign ser_out    = ((state_q == SHIFT) && sh_msb) || ((state_q == PAR) && par_q);
`else
   assign ser_out    = (state_q == SHIFT) && sh_msb;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios plus random words and random ser_ready,
// checked against a bit-queue model of each word.
module tb_piso_serializer;

   localparam int W = 16;
`ifdef PISO_PARITY_EN
   localparam int BEATS = W + 1;
`else
   localparam int BEATS = W;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] d;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_ready;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .d         (d),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ser_valid"}, ser_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_load_ready"}, load_ready, 1'b1);
      chk({tag, "_ser_out"}, ser_out, 1'b0);
   endtask

   // Called at a negedge with the DUT idle. Offers `word`, then consumes it while
   // comparing every cycle against the expected bit queue. During the word,
   // load_valid/d are driven with hold_vld/hold_d (must be ignored by the DUT).
   // abort_at >= 0 pulses rst once that many bits have been accepted.
   task automatic run_word(input logic [W-1:0] word, input int rdy_pct,
                           input int stall_at, input int stall_len,
                           input bit hold_vld, input logic [W-1:0] hold_d,
                           input int abort_at);
      bit exp_q[$];
      int beat;
      int cyc;
      int stalled;
      bit rdy;
      beat = 0;
      cyc = 0;
      stalled = 0;
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef PISO_PARITY_EN
      exp_q.push_back(^word);
`endif
      chk("load_ready_before_load", load_ready, 1'b1);
      load_valid = 1'b1;
      d = word;
      ser_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      load_valid = hold_vld;
      d = hold_d;
      while (exp_q.size() > 0 && cyc < 8 * BEATS) begin
         chk("ser_valid_in_word", ser_valid, 1'b1);
         chk("busy_in_word", busy, 1'b1);
         chk("load_ready_in_word", load_ready, 1'b0);
         chk("done_in_word", done, 1'b0);
         chk($sformatf("ser_out_bit%0d", beat), ser_out, exp_q[0]);
         if (beat == abort_at) begin
            load_valid = 1'b0;
            ser_ready = 1'b1;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_idle("abort");
            chk("abort_done", done, 1'b0);
            @(negedge clk);
            chk("abort_done_next", done, 1'b0);
            chk_idle("abort_next");
            return;
         end
         if (beat == stall_at && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end else begin
            rdy = (int'($urandom_range(1, 100)) <= rdy_pct);
         end
         ser_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) begin
            void'(exp_q.pop_front());
            beat++;
         end
      end
      chk("word_completed_in_budget", exp_q.size() == 0, 1'b1);
      chk("done_pulse", done, 1'b1);
      chk_idle("done_cycle");
      load_valid = 1'b0;
      ser_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] rw;
      logic [W-1:0] rh;
      rst = 1'b1;
      load_valid = 1'b0;
      d = '0;
      ser_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset");
      chk("reset_done", done, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("post_reset");

      // Basic word, ser_ready always high; done must not persist.
      run_word(16'hA5C3, 100, -1, 0, 1'b0, '0, -1);
      @(negedge clk);
      chk("done_single_pulse", done, 1'b0);
      chk_idle("after_basic");

      // Three stall cycles at bit index 5.
      run_word(16'h8001, 100, 5, 3, 1'b0, '0, -1);

      // Load offered while busy must be ignored.
      run_word(16'h1234, 100, -1, 0, 1'b1, 16'hFFFF, -1);

      // Reset after 8 accepted bits.
      run_word(16'h5A5A, 100, -1, 0, 1'b0, '0, 8);

      // Back-to-back: second word accepted in the done cycle.
      run_word(16'h0F0F, 100, -1, 0, 1'b1, 16'hF0F0, -1);
      run_word(16'hF0F0, 100, -1, 0, 1'b1, 16'hF0F0, -1);

`ifdef PISO_PARITY_EN
      run_word(16'h0001, 100, -1, 0, 1'b0, '0, -1);
      run_word(16'h0003, 100, -1, 0, 1'b0, '0, -1);
`endif

      // Random words with random backpressure and ignored loads.
      for (int n = 0; n < 24; n++) begin
         rw = W'($urandom);
         rh = W'($urandom);
         run_word(rw, int'($urandom_range(30, 100)), -1, 0,
                  1'($urandom_range(0, 1)), rh, -1);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("gap_done", done, 1'b0);
            chk_idle("gap");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
